// File: rtl/discr_scaler_multi_pkg.sv
// Shared types and helpers for the multi-channel discriminator scaler:
// readout state encoding, inhibit counter width and a saturating adder.
package discr_scaler_multi_pkg;

  localparam int INHIB_W = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;

  // a + b clipped to an n-bit all-ones ceiling (n <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned n);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << n) - 33'd1;
    sat_add = (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/discr_scaler_multi_chan_counter.sv
// One discriminator channel: rising-edge detect across a deserialised word,
// dead-time inhibit spanning words, and a saturating per-period accumulator.
module discr_chan_counter
  import discr_scaler_multi_pkg::*;
#(
  parameter int P_N_BITS  = 8,
  parameter int P_N_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [P_N_BITS-1:0]  samples,
  input  logic                 en,
  input  logic [INHIB_W-1:0]   inhibit_len,
  input  logic                 clear,
  output logic [P_N_WIDTH-1:0] count
);

  localparam int EW = $clog2(P_N_BITS + 1);

  logic                 prev_reg;
  logic                 prev_chain;
  logic [INHIB_W-1:0]   inh_reg;
  logic [INHIB_W-1:0]   inh_next;
  logic [EW-1:0]        edge_cnt;
  logic [P_N_WIDTH-1:0] acc_reg;
  logic [P_N_WIDTH-1:0] acc_sum;

  // Samples are walked earliest-first so an edge can inhibit later ones in the same word.
  always_comb begin
    prev_chain = prev_reg;
    inh_next   = inh_reg;
    edge_cnt   = '0;
    for (int i = 0; i < P_N_BITS; i++) begin
      if (inh_next != '0) begin
        inh_next = inh_next - INHIB_W'(1);
      end else if (samples[i] && !prev_chain) begin
        edge_cnt = edge_cnt + EW'(1);
        inh_next = inhibit_len;
      end
      prev_chain = samples[i];
    end
  end

  assign acc_sum = P_N_WIDTH'(sat_add(32'(acc_reg), 32'(edge_cnt), P_N_WIDTH));
  // Includes this clk's edges so a boundary snapshot sees the whole period.
  assign count   = en ? acc_sum : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= 1'b0;
      inh_reg  <= '0;
      acc_reg  <= '0;
    end else begin
      prev_reg <= samples[P_N_BITS-1];
      inh_reg  <= inh_next;
      acc_reg  <= (clear || !en) ? '0 : acc_sum;
    end
  end

endmodule

// File: rtl/discr_scaler_multi.sv
// Multi-channel discriminator scaler: per-channel edge counters, period timer,
// boundary snapshot and a one-channel-per-beat valid/ready readout stream.
module discr_scaler_multi
  import discr_scaler_multi_pkg::*;
#(
  parameter int P_N_CHAN  = 4,
  parameter int P_N_BITS  = 8,
  parameter int P_N_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [P_N_CHAN*P_N_BITS-1:0] discr_in,
  input  logic [P_N_CHAN-1:0]          chan_en,
  input  logic [31:0]                  inhibit_len,
  input  logic [31:0]                  period,
  output logic                         valid,
  output logic                         update_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(P_N_CHAN)-1:0]  out_chan,
  output logic [P_N_WIDTH-1:0]         out_count,
  output logic                         out_last,
  output logic                         overrun
);

  localparam int CW = $clog2(P_N_CHAN);

  logic [P_N_WIDTH-1:0] chan_count [P_N_CHAN];
  logic [P_N_WIDTH-1:0] snap_reg   [P_N_CHAN];

  logic [31:0] per_cnt_reg;
  logic [31:0] per_len_reg;
  logic        len_ok_reg;
  logic [31:0] period_clamped;
  logic [31:0] eff_len;
  logic        boundary;

  rd_state_t   state_reg;
  rd_state_t   state_next;
  logic [CW-1:0] chan_reg;
  logic [CW-1:0] chan_next;
  logic        valid_reg;
  logic        overrun_reg;
  logic        take_snap;
  logic        drop_snap;

  // The first period after reset takes its length straight from the input;
  // afterwards the length only changes at a boundary.
  assign period_clamped = (period == '0) ? 32'd1 : period;
  assign eff_len        = len_ok_reg ? per_len_reg : period_clamped;
  assign boundary       = !rst && (per_cnt_reg == eff_len - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt_reg <= '0;
      per_len_reg <= '0;
      len_ok_reg  <= 1'b0;
    end else if (boundary) begin
      per_cnt_reg <= '0;
      per_len_reg <= period_clamped;
      len_ok_reg  <= 1'b1;
    end else begin
      per_cnt_reg <= per_cnt_reg + 32'd1;
      if (!len_ok_reg) begin
        per_len_reg <= period_clamped;
        len_ok_reg  <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < P_N_CHAN; gi++) begin : g_chan
      discr_chan_counter #(
        .P_N_BITS (P_N_BITS),
        .P_N_WIDTH(P_N_WIDTH)
      ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .samples    (discr_in[gi*P_N_BITS +: P_N_BITS]),
        .en         (chan_en[gi]),
        .inhibit_len(inhibit_len),
        .clear      (boundary),
        .count      (chan_count[gi])
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          snap_reg[gi] <= '0;
        end else if (take_snap) begin
          snap_reg[gi] <= chan_count[gi];
        end
      end
    end
  endgenerate

  // A boundary during STREAM (even on the final beat) drops the new counts.
  always_comb begin
    state_next = state_reg;
    chan_next  = chan_reg;
    take_snap  = 1'b0;
    drop_snap  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (boundary) begin
          take_snap  = 1'b1;
          state_next = ST_STREAM;
          chan_next  = '0;
        end
      end
      ST_STREAM: begin
        drop_snap = boundary;
        if (out_ready) begin
          if (chan_reg == CW'(P_N_CHAN - 1)) begin
            state_next = ST_IDLE;
            chan_next  = '0;
          end else begin
            chan_next = chan_reg + CW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      chan_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      chan_reg  <= chan_next;
      if (take_snap) valid_reg <= 1'b1;
      if (drop_snap) overrun_reg <= 1'b1;
    end
  end

  assign update_out = take_snap;
  assign out_valid  = (state_reg == ST_STREAM);
  assign out_chan   = chan_reg;
  assign out_count  = snap_reg[chan_reg];
  assign out_last   = out_valid && (chan_reg == CW'(P_N_CHAN - 1));
  assign valid      = valid_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_discr_scaler_multi.sv
// Randomised and directed bench for discr_scaler_multi against a sample-stream
// reference model; a second instance with 4-bit counts exercises saturation.
module tb_discr_scaler_multi;

  localparam int N  = 4;
  localparam int B  = 8;
  localparam int W  = 16;
  localparam int WS = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*B-1:0] discr_in = '0;
  logic [N-1:0]   chan_en = '1;
  logic [31:0]    inhibit_len = '0;
  logic [31:0]    period = 32'd3;
  logic           out_ready = 1'b1;

  logic           valid_a, upd_a, ov_a, last_a, ovr_a;
  logic [1:0]     chan_a;
  logic [W-1:0]   cnt_a;
  logic           valid_b, upd_b, ov_b, last_b, ovr_b;
  logic [1:0]     chan_b;
  logic [WS-1:0]  cnt_b;

  always #5 clk = ~clk;

  discr_scaler_multi #(.P_N_CHAN(N), .P_N_BITS(B), .P_N_WIDTH(W)) u_dut_a (
    .clk(clk), .rst(rst), .discr_in(discr_in), .chan_en(chan_en),
    .inhibit_len(inhibit_len), .period(period), .valid(valid_a),
    .update_out(upd_a), .out_valid(ov_a), .out_ready(out_ready),
    .out_chan(chan_a), .out_count(cnt_a), .out_last(last_a), .overrun(ovr_a)
  );

  discr_scaler_multi #(.P_N_CHAN(N), .P_N_BITS(B), .P_N_WIDTH(WS)) u_dut_b (
    .clk(clk), .rst(rst), .discr_in(discr_in), .chan_en(chan_en),
    .inhibit_len(inhibit_len), .period(period), .valid(valid_b),
    .update_out(upd_b), .out_valid(ov_b), .out_ready(out_ready),
    .out_chan(chan_b), .out_count(cnt_b), .out_last(last_b), .overrun(ovr_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: each channel is a flat sample stream; an edge counts if it
  // lies beyond the blocked window of the previous counted edge.
  bit     m_prev  [N];
  longint m_block [N];
  longint m_cnt   [N];
  longint m_snap  [N];
  longint m_sidx;
  int     m_beat;
  bit     m_valid, m_ovr;
  longint m_pos, m_len;
  bit     m_len_ok;
  bit     chk_on = 1'b0;

  function automatic longint clampp(input logic [31:0] p);
    return (p == 0) ? 64'd1 : longint'(p);
  endfunction

  function automatic longint satw(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_prev[c] = 1'b0; m_block[c] = -1; m_cnt[c] = 0; m_snap[c] = 0;
    end
    m_sidx = 0; m_beat = -1; m_valid = 1'b0; m_ovr = 1'b0;
    m_pos = 0; m_len = 0; m_len_ok = 1'b0;
  endtask

  task automatic cycle(input bit r, input logic [N*B-1:0] d, input logic [N-1:0] en,
                       input logic [31:0] inh, input logic [31:0] per, input bit rdy);
    longint eff;
    bit     bnd, stream;
    @(negedge clk);
    rst = r; discr_in = d; chan_en = en; inhibit_len = inh; period = per; out_ready = rdy;
    #1;
    eff = m_len_ok ? m_len : clampp(per);
    bnd = (m_pos == eff - 1);
    if (chk_on) begin
      check_val("update_out", 32'(upd_a), 32'(!r && bnd && m_beat < 0));
      check_val("update_out_b", 32'(upd_b), 32'(!r && bnd && m_beat < 0));
      check_val("valid", 32'(valid_a), 32'(m_valid));
      check_val("overrun", 32'(ovr_a), 32'(m_ovr));
      check_val("out_valid", 32'(ov_a), 32'(m_beat >= 0));
      if (m_beat >= 0) begin
        check_val("out_chan", 32'(chan_a), 32'(m_beat));
        check_val("out_last", 32'(last_a), 32'(m_beat == N - 1));
        check_val("out_count", 32'(cnt_a), 32'(satw(m_snap[m_beat], W)));
        check_val("out_count_sat4", 32'(cnt_b), 32'(satw(m_snap[m_beat], WS)));
      end
    end
    if (r) begin
      model_reset();
    end else begin
      stream = (m_beat >= 0);
      for (int c = 0; c < N; c++) begin
        for (int i = 0; i < B; i++) begin
          bit     s;
          longint p;
          s = d[c*B + i];
          p = m_sidx + i;
          if (s && !m_prev[c] && p > m_block[c]) begin
            m_cnt[c]++;
            m_block[c] = p + longint'(inh);
          end
          m_prev[c] = s;
        end
        if (!en[c]) m_cnt[c] = 0;
      end
      m_sidx += B;
      if (stream && rdy) m_beat = (m_beat == N - 1) ? -1 : m_beat + 1;
      if (bnd) begin
        if (!stream) begin
          for (int c = 0; c < N; c++) m_snap[c] = m_cnt[c];
          m_beat = 0; m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        for (int c = 0; c < N; c++) m_cnt[c] = 0;
        m_pos = 0; m_len = clampp(per); m_len_ok = 1'b1;
      end else begin
        m_pos++;
        if (!m_len_ok) begin m_len = clampp(per); m_len_ok = 1'b1; end
      end
    end
  endtask

  task automatic do_reset(input logic [31:0] per);
    cycle(1'b1, '0, '1, 32'd0, per, 1'b1);
    cycle(1'b1, '0, '1, 32'd0, per, 1'b1);
  endtask

  initial begin
    logic [31:0] inh_r, per_r;
    logic [N-1:0] en_r;
    int guard;

    model_reset();
    do_reset(32'd3);
    chk_on = 1'b1;

    // T1: ch0 0x55 then 0xAA, period 3, streaming every period
    do_reset(32'd3);
    cycle(1'b0, 32'h0000_0055, '1, 32'd0, 32'd3, 1'b1);
    cycle(1'b0, 32'h0000_00AA, '1, 32'd0, 32'd3, 1'b1);
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, '1, 32'd0, 32'd3, 1'b1);

    // T2: 0x55 on all channels, long period; 4-bit instance must saturate
    do_reset(32'd12);
    for (int k = 0; k < 18; k++) cycle(1'b0, 32'h5555_5555, '1, 32'd0, 32'd12, 1'b1);

    // T3: inhibit 3 halves the 0x55 edge rate; 0x80/0x01 straddle gives one edge
    do_reset(32'd6);
    for (int k = 0; k < 7; k++) cycle(1'b0, 32'h5555_5555, '1, 32'd3, 32'd6, 1'b1);
    cycle(1'b0, 32'h0000_0000, '1, 32'd0, 32'd6, 1'b1);
    cycle(1'b0, 32'h8080_8080, '1, 32'd0, 32'd6, 1'b1);
    cycle(1'b0, 32'h0101_0101, '1, 32'd0, 32'd6, 1'b1);
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, '1, 32'd0, 32'd6, 1'b1);

    // T4: out_ready low across two boundaries -> overrun, first snapshot intact
    do_reset(32'd5);
    for (int k = 0; k < 12; k++) cycle(1'b0, $urandom & $urandom, '1, 32'd0, 32'd5, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b0, $urandom & $urandom, '1, 32'd0, 32'd5, 1'b1);

    // T5: period 3 -> 10 mid-period
    do_reset(32'd3);
    for (int k = 0; k < 4; k++) cycle(1'b0, $urandom, '1, 32'd0, 32'd3, 1'b1);
    for (int k = 0; k < 30; k++) cycle(1'b0, $urandom, '1, 32'd0, 32'd10, 1'b1);

    // T6: ch1 disabled; reset lands on beat 2 of a stream
    do_reset(32'd6);
    guard = 0;
    while (m_beat != 2 && guard < 40) begin
      cycle(1'b0, $urandom, 4'b1101, 32'd1, 32'd6, 1'b1);
      guard++;
    end
    check_val("beat2_reached", 32'(m_beat == 2), 32'd1);
    cycle(1'b1, '0, 4'b1101, 32'd1, 32'd6, 1'b1);
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, $urandom, 4'b1101, 32'd1, 32'd6, 1'b1);
      #5;
      if (m_beat == 1) check_val("ch1_disabled", 32'(cnt_a), 32'd0);
    end

    // Random: sparse hits, varying inhibit, period, enables and backpressure
    do_reset(32'd7);
    inh_r = 32'd2; per_r = 32'd7; en_r = '1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 63) == 0) inh_r = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 63) == 0) per_r = 32'($urandom_range(0, 12));
      if ($urandom_range(0, 127) == 0) en_r = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 999) == 0) cycle(1'b1, '0, en_r, inh_r, per_r, 1'b1);
      else cycle(1'b0, $urandom & $urandom, en_r, inh_r, per_r, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
